hc595_receiver: RTL and testbench
=================================

# hc595_receiver

Serial-to-parallel receiver for the 74HC595 three-wire interface (sh_cp / st_cp / ds) produced by hc595_driver. It samples the three lines in the `clk` domain, rebuilds the shift and storage registers of a DATA_WIDTH-bit 595 chain, and presents the latched word with a one-cycle valid strobe plus frame-length checking. Used as a loopback checker for the seven-segment driver path and as a synthesizable stand-in for the physical 595 chain.

## Interface
- DATA_WIDTH, 16, number of bits per frame (chain length); must be ≥ 2.
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- sh_cp  input  1  shift clock from driver; asynchronous to clk; rising edge shifts.
- st_cp  input  1  storage (latch) clock from driver; asynchronous to clk; rising edge latches.
- ds  input  1  serial data, MSB first; asynchronous to clk.
- data_out  output  DATA_WIDTH  last latched word.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  set on a latch whose bit count ≠ DATA_WIDTH; cleared on a latch with exact count.
- frame_cnt  output  8  count of latch events; wraps 255 → 0.

## Operation
- Synchronizers: sh_cp, st_cp and ds each pass through two flops (s1, s2); all three paths have equal delay, so ds stays aligned with sh_cp.
- Edge detect: a previous-level flop per clock line; rise = s2 & ~prev.
- Arming: per clock line, an `armed` flag, cleared by reset and set the first cycle its s2 is 0. Rises are ignored while not armed, so a line held high through reset release produces no event.
- Shift on sh_cp rise: shift_reg ← {shift_reg[DATA_WIDTH-2:0], ds_s2}. bit_cnt increments and saturates at 2·DATA_WIDTH−1.
- Latch on st_cp rise:
  - data_out ← shift_reg.
  - data_valid = 1 for that cycle.
  - frame_err ← (bit_cnt ≠ DATA_WIDTH).
  - frame_cnt increments.
  - bit_cnt ← 0.
- Simultaneous sh_cp rise and st_cp rise in the same clk cycle follow 595 semantics:
  - data_out takes the pre-shift shift_reg.
  - The shift still happens.
  - bit_cnt ← 1 (the new bit belongs to the next frame).
  - frame_err is judged on the pre-shift count.
- Overlong frame (more than DATA_WIDTH shifts): shift_reg holds the last DATA_WIDTH bits; frame_err = 1 on latch.
- Short frame: shift_reg holds the old bits shifted up, with new bits in the LSBs; data_out = that value; frame_err = 1.
- Shifts with no following latch leave data_out unchanged.
- Reset values: all synchronizer, prev and armed flops 0; shift_reg 0; bit_cnt 0; data_out 0; data_valid 0; frame_err 0; frame_cnt 0.
- Reset asserted mid-frame: partial frame discarded, everything returns to reset values immediately (asynchronous).

## Timing
- Input rise sampled at clk edge N: s1 at N, s2 at N+1, register update at N+2. Effect is visible after edge N+2, i.e. 3-edge latency from pin to shift_reg, data_out and data_valid.
- data_valid is high exactly one clk cycle, coincident with the first cycle of the new data_out.
- Minimum input pulse: sh_cp and st_cp high ≥ 3 clk and low ≥ 3 clk.
- ds must be stable from 3 clk before to 1 clk after its sh_cp rise. The hc595_driver timing (ds set half a sh_cp period ahead) meets this.
- Back-to-back latches are allowed once the 3-clk minimum low time is met; each produces its own data_valid.

## Test plan
- hc595_driver with data 16'b1010_1111_0110_0101 (16'hAF65), s_en=1 → data_out = 16'hAF65, one data_valid pulse per frame, frame_err = 0, frame_cnt increments each frame; then switch to 16'h55A5 → data_out = 16'h55A5 after the next latch.
- Hand-driven frame of 12 bits 0xABC after a clean 16'hFFFF frame → data_out = 16'hFABC, frame_err = 1. A following exact 16-bit frame 16'h1234 → data_out = 16'h1234, frame_err = 0.
- 20-bit frame 0xFEDCB → data_out = 16'hEDCB, frame_err = 1.
- Shift 16'hA5A5, then a 17th sh_cp rise (ds = 1) in the same clk cycle as the st_cp rise → data_out = 16'hA5A5, frame_err = 0. Next latch after 15 more bits reports frame_err = 0.
- Reset pulse after 8 of 16 bits, then a full frame 16'h0F0F → all outputs 0 during reset; after the frame, data_out = 16'h0F0F, frame_err = 0, frame_cnt = 1.
- sh_cp and st_cp held high across reset release, then low, then a normal frame 16'h00FF → no data_valid and no shift until the lines go low; then data_out = 16'h00FF, frame_cnt = 1.

Source files
------------

// File: rtl/hc595_receiver_if.sv
// Three-wire 74HC595 link plus the parallel result of the receiver.
// master drives the serial lines, slave rebuilds the word.
interface hc595_receiver_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  sh_cp;
  logic                  st_cp;
  logic                  ds;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  frame_err;
  logic [7:0]            frame_cnt;

  modport master (
    output sh_cp, st_cp, ds,
    input  data_out, data_valid, frame_err, frame_cnt
  );

  modport slave (
    input  sh_cp, st_cp, ds,
    output data_out, data_valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/hc595_receiver.sv
// Rebuilds a DATA_WIDTH-bit 595 shift/storage chain from asynchronous sh_cp/st_cp/ds
// lines, reporting each latched word with a valid strobe and frame-length check.
module hc595_receiver #(
  parameter int DATA_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  hc595_receiver_if.slave    bus
);

  localparam int CNT_W = $clog2(2 * DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int SH = 0;
  localparam int ST = 1;
  localparam int DS = 2;

  logic [2:0]            pins;
  logic [2:0]            s1_q, s1_d;
  logic [2:0]            s2_q, s2_d;
  logic [1:0]            fill_q, fill_d;
  logic [1:0]            prev_q, prev_d;
  logic [1:0]            armed_q, armed_d;
  logic [1:0]            rise;
  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;

  assign pins = {bus.ds, bus.st_cp, bus.sh_cp};

  // fill_q marks when s2 holds a genuinely sampled level rather than its reset 0,
  // so a line held high through reset release never looks like a low-to-high edge.
  always_comb begin
    s1_d   = pins;
    s2_d   = s1_q;
    fill_d = {fill_q[0], 1'b1};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    assign prev_d[gi]  = s2_q[gi];
    assign armed_d[gi] = armed_q[gi] | (fill_q[1] & ~s2_q[gi]);
    assign rise[gi]    = s2_q[gi] & ~prev_q[gi] & armed_q[gi];
  end

  always_comb begin
    shift_reg_d  = shift_reg_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    frame_cnt_d  = frame_cnt_q;

    if (rise[SH]) begin
      shift_reg_d = {shift_reg_q[DATA_WIDTH-2:0], s2_q[DS]};
      if (bit_cnt_q != CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + CNT_ONE;
      end
    end

    // Latch sees the pre-shift register and count; a coincident shift opens the next frame.
    if (rise[ST]) begin
      data_out_d   = shift_reg_q;
      data_valid_d = 1'b1;
      frame_err_d  = (bit_cnt_q != CNT_FULL);
      frame_cnt_d  = frame_cnt_q + 8'd1;
      bit_cnt_d    = rise[SH] ? CNT_ONE : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      fill_q       <= '0;
      prev_q       <= '0;
      armed_q      <= '0;
      shift_reg_q  <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      fill_q       <= fill_d;
      prev_q       <= prev_d;
      armed_q      <= armed_d;
      shift_reg_q  <= shift_reg_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_hc595_receiver.sv
// Drives 595-style frames into hc595_receiver and scores each latched word.
module tb_hc595_receiver;

  logic clk;
  logic reset;

  hc595_receiver_if #(.DATA_WIDTH(16)) bus ();

  hc595_receiver #(.DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[7];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_cnt  = 8'd0;
  logic       prev_v   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic e);
    exp_t x;
    exp_cnt = exp_cnt + 8'd1;
    x.data = d;
    x.err  = e;
    x.cnt  = exp_cnt;
    sb.push_back(x);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("valid_seen", sb.size(), 0);
    sb.delete();
  endtask

  task automatic shift_bit(input logic b);
    bus.ds = b;
    repeat (4) @(posedge clk);
    #1 bus.sh_cp = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.sh_cp = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic latch(input logic [15:0] d, input logic e);
    push_exp(d, e);
    repeat (4) @(posedge clk);
    #1 bus.st_cp = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.st_cp = 1'b0;
    repeat (4) @(posedge clk);
    wait_drain();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_out"},   bus.data_out,   0);
    chk({tag, "_data_valid"}, bus.data_valid, 0);
    chk({tag, "_frame_err"},  bus.frame_err,  0);
    chk({tag, "_frame_cnt"},  bus.frame_cnt,  0);
  endtask

  initial begin
    vecs[0] = '{32'h0000AF65, 16, 16'hAF65, 1'b0};
    vecs[1] = '{32'h0000AF65, 16, 16'hAF65, 1'b0};
    vecs[2] = '{32'h000055A5, 16, 16'h55A5, 1'b0};
    vecs[3] = '{32'h0000FFFF, 16, 16'hFFFF, 1'b0};
    vecs[4] = '{32'h00000ABC, 12, 16'hFABC, 1'b1};
    vecs[5] = '{32'h00001234, 16, 16'h1234, 1'b0};
    vecs[6] = '{32'h000FEDCB, 20, 16'hEDCB, 1'b1};

    reset     = 1'b1;
    bus.sh_cp = 1'b0;
    bus.st_cp = 1'b0;
    bus.ds    = 1'b0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (bus.data_valid) begin
          chk("valid_width", prev_v, 0);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=1 required=0 data_out=%h", bus.data_out);
          end else begin
            e = sb.pop_front();
            chk("data_out",  bus.data_out,  e.data);
            chk("frame_err", bus.frame_err, e.err);
            chk("frame_cnt", bus.frame_cnt, e.cnt);
            $display("frame data_out=%h frame_err=%0d frame_cnt=%0d", bus.data_out, bus.frame_err, bus.frame_cnt);
          end
        end
        prev_v = bus.data_valid;
      end
    join_none

    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].bits, vecs[v].nbits);
      latch(vecs[v].exp_data, vecs[v].exp_err);
    end

    // 17th shift coincides with the latch: it must land in the next frame.
    send_frame(32'h0000A5A5, 16);
    bus.ds = 1'b1;
    repeat (4) @(posedge clk);
    push_exp(16'hA5A5, 1'b0);
    #1 begin
      bus.sh_cp = 1'b1;
      bus.st_cp = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1 begin
      bus.sh_cp = 1'b0;
      bus.st_cp = 1'b0;
    end
    repeat (4) @(posedge clk);
    wait_drain();
    send_frame(32'h0, 15);
    latch(16'h8000, 1'b0);

    // Partial frame then asynchronous reset mid-frame.
    send_frame(32'h0000003C, 8);
    repeat (6) @(posedge clk);
    chk("no_latch_hold", bus.data_out, 16'h8000);
    @(posedge clk);
    #3 reset = 1'b1;
    #2 chk_zero("mid_reset");
    sb.delete();
    exp_cnt = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    send_frame(32'h00000F0F, 16);
    latch(16'h0F0F, 1'b0);

    // Clock lines held high through reset release must not produce events.
    @(posedge clk);
    #1 begin
      reset     = 1'b1;
      bus.sh_cp = 1'b1;
      bus.st_cp = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = 8'd0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_zero("held_high");
    @(posedge clk);
    #1 begin
      bus.sh_cp = 1'b0;
      bus.st_cp = 1'b0;
    end
    repeat (6) @(posedge clk);
    send_frame(32'h000000FF, 16);
    latch(16'h00FF, 1'b0);

    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
